fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 30 +++
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PCSrc encoding, FSM state type and the NOP word.
// The control unit imports the same PCSrc constants.
package fetch_pkg;

   localparam logic [1:0]  PC_SRC_PLUS4  = 2'b00;
   localparam logic [1:0]  PC_SRC_TARGET = 2'b01;
   localparam logic [1:0]  PC_SRC_JALR   = 2'b10;

   localparam logic [31:0] NOP_INSTR_C   = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      FETCH = 2'b01,
      VALID = 2'b10,
      FAULT = 2'b11
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux driven by PCSrc; also flags a target that is not word aligned.
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic [1:0]            i_pc_src,
   input  logic [DATA_WIDTH-1:0] i_pcd,
   input  logic [DATA_WIDTH-1:0] i_pc_target,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   output logic [DATA_WIDTH-1:0] o_next_pc,
   output logic                  o_misaligned
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

   // Select the next PC; the reserved encoding behaves like sequential flow
   always_comb begin
      o_next_pc = i_pcd + PC_STEP;
      case (i_pc_src)
         PC_SRC_PLUS4:  o_next_pc = i_pcd + PC_STEP;
         PC_SRC_TARGET: o_next_pc = i_pc_target;
         PC_SRC_JALR:   o_next_pc = {i_alu_result[DATA_WIDTH-1:1], 1'b0};
         default:       o_next_pc = i_pcd + PC_STEP;
      endcase
   end

   assign o_misaligned = is_misaligned(o_next_pc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch and a valid/ready handoff to decode.
// Optional FETCH_MISALIGN_TRAP_EN adds a terminal FAULT state and the FetchFault output.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_C)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            PCSrc,
   input  logic [DATA_WIDTH-1:0] PCTarget,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  ImemReq,
   output logic [DATA_WIDTH-1:0] ImemAddr,
   input  logic                  ImemAck,
   input  logic [DATA_WIDTH-1:0] ImemRdata,
   output logic                  InstrValid,
   input  logic                  InstrReady,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  FetchFault
`else
   output logic [DATA_WIDTH-1:0] PCPlus4D
`endif
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(32'd4);

   fetch_state_t          r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
   logic                  r_imem_req, w_req_nxt;
   logic [DATA_WIDTH-1:0] r_imem_addr, w_addr_nxt;
   logic                  r_instr_valid, w_valid_nxt;
   logic [DATA_WIDTH-1:0] r_instr_d, w_instr_nxt;
   logic [DATA_WIDTH-1:0] r_pcd, w_pcd_nxt;
   logic [DATA_WIDTH-1:0] r_pcplus4d, w_pcplus4_nxt;
   logic [DATA_WIDTH-1:0] w_next_pc;
   logic [DATA_WIDTH-1:0] w_pc_load;
   logic                  w_misaligned;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic                  r_fetch_fault, w_fault_nxt;
`endif

   next_pc_sel #(
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_next_pc_sel (
      .i_pc_src     (PCSrc),
      .i_pcd        (r_pcd),
      .i_pc_target  (PCTarget),
      .i_alu_result (ALUResult),
      .o_next_pc    (w_next_pc),
      .o_misaligned (w_misaligned)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_pc_load = w_next_pc;
`else
   // Without the trap, a misaligned target is silently word-aligned
   assign w_pc_load = w_misaligned ? {w_next_pc[DATA_WIDTH-1:2], 2'b00} : w_next_pc;
`endif

   // Next-state and next-output logic; every output is registered
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_req_nxt     = r_imem_req;
      w_addr_nxt    = r_imem_addr;
      w_valid_nxt   = r_instr_valid;
      w_instr_nxt   = r_instr_d;
      w_pcd_nxt     = r_pcd;
      w_pcplus4_nxt = r_pcplus4d;
`ifdef FETCH_MISALIGN_TRAP_EN
      w_fault_nxt   = r_fetch_fault;
`endif
      case (r_state)
         BOOT: begin
            w_state_nxt = FETCH;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
         end
         FETCH: begin
            if (ImemAck) begin
               w_state_nxt   = VALID;
               w_req_nxt     = 1'b0;
               w_valid_nxt   = 1'b1;
               w_instr_nxt   = ImemRdata;
               w_pcd_nxt     = r_pc;
               w_pcplus4_nxt = r_pc + PC_STEP;
            end else begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_pc;
               w_valid_nxt = 1'b0;
            end
         end
         VALID: begin
            if (InstrReady) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (w_misaligned) begin
                  w_state_nxt = FAULT;
                  w_pc_nxt    = w_next_pc;
                  w_req_nxt   = 1'b0;
                  w_valid_nxt = 1'b0;
                  w_instr_nxt = NOP_INSTR;
                  w_fault_nxt = 1'b1;
               end else begin
                  w_state_nxt = FETCH;
                  w_pc_nxt    = w_pc_load;
                  w_req_nxt   = 1'b1;
                  w_addr_nxt  = w_pc_load;
                  w_valid_nxt = 1'b0;
                  w_instr_nxt = NOP_INSTR;
               end
`else
               w_state_nxt = FETCH;
               w_pc_nxt    = w_pc_load;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = w_pc_load;
               w_valid_nxt = 1'b0;
               w_instr_nxt = NOP_INSTR;
`endif
            end else begin
               w_req_nxt   = 1'b0;
               w_valid_nxt = 1'b1;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         FAULT: begin
            w_req_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
            w_fault_nxt = 1'b1;
         end
`endif
         default: begin
            w_state_nxt = BOOT;
            w_pc_nxt    = RESET_PC;
            w_req_nxt   = 1'b0;
            w_addr_nxt  = RESET_PC;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
         end
      endcase
   end

   // State, PC and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= BOOT;
         r_pc          <= RESET_PC;
         r_imem_req    <= 1'b0;
         r_imem_addr   <= RESET_PC;
         r_instr_valid <= 1'b0;
         r_instr_d     <= NOP_INSTR;
         r_pcd         <= RESET_PC;
         r_pcplus4d    <= RESET_PC + PC_STEP;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_fetch_fault <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_imem_req    <= w_req_nxt;
         r_imem_addr   <= w_addr_nxt;
         r_instr_valid <= w_valid_nxt;
         r_instr_d     <= w_instr_nxt;
         r_pcd         <= w_pcd_nxt;
         r_pcplus4d    <= w_pcplus4_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_fetch_fault <= w_fault_nxt;
`endif
      end
   end

   assign ImemReq    = r_imem_req;
   assign ImemAddr   = r_imem_addr;
   assign InstrValid = r_instr_valid;
   assign InstrD     = r_instr_d;
   assign PCD        = r_pcd;
   assign PCPlus4D   = r_pcplus4d;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign FetchFault = r_fetch_fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scripted memory/decoder plus a next-PC reference model.
// Works with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] PCTarget = 32'h0;
   logic [31:0] ALUResult = 32'h0;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck = 1'b0;
   logic [31:0] ImemRdata = 32'h0;
   logic        InstrValid;
   logic        InstrReady = 1'b0;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        FetchFault;
`endif

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic [31:0] cur_addr;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .PCSrc      (PCSrc),
      .PCTarget   (PCTarget),
      .ALUResult  (ALUResult),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .ImemAck    (ImemAck),
      .ImemRdata  (ImemRdata),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,.FetchFault(FetchFault)
`endif
   );

   // Memory contents as a pure function of the address
   function automatic logic [31:0] instr_at(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] pc,
                                              input logic [31:0] tgt, input logic [31:0] alu);
      logic [31:0] n;
      if (src == 2'd1)      n = tgt;
      else if (src == 2'd2) n = alu & 32'hFFFF_FFFE;
      else                  n = pc + 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
      n = n & 32'hFFFF_FFFC;
`endif
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; ImemAck = 1'b0; InstrReady = 1'b0;
      step();
      rst = 1'b0;
      step();
      cur_addr = 32'h0;
   endtask

   // One full fetch at addr: optional ack delay, optional decode stall, then consume with src
   task automatic do_fetch(input logic [31:0] addr, input int delay, input int stall,
                           input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                           output logic [31:0] nxt);
      logic [31:0] ins;
      n_total++;
      if ({ImemReq, ImemAddr, InstrValid, InstrD} !== {1'b1, addr, 1'b0, NOP})
         $display("FAIL fetch_req: req=%0b addr=%h valid=%0b instr=%h, want 1 %h 0 %h",
                  ImemReq, ImemAddr, InstrValid, InstrD, addr, NOP);
      else n_pass++;
      for (int i = 0; i < delay; i++) begin
         ImemAck = 1'b0; InstrReady = 1'($urandom);
         step();
         n_total++;
         if ({ImemReq, ImemAddr, InstrValid} !== {1'b1, addr, 1'b0})
            $display("FAIL fetch_wait: req=%0b addr=%h valid=%0b, want 1 %h 0",
                     ImemReq, ImemAddr, InstrValid, addr);
         else n_pass++;
      end
      InstrReady = 1'b0;
      ins = instr_at(addr);
      ImemAck = 1'b1; ImemRdata = ins;
      step();
      ImemAck = 1'b0; ImemRdata = $urandom;
      for (int i = 0; i <= stall; i++) begin
         n_total++;
         if ({InstrValid, ImemReq, InstrD, PCD, PCPlus4D} !== {1'b1, 1'b0, ins, addr, addr + 32'd4})
            $display("FAIL valid_out: v=%0b req=%0b instr=%h pcd=%h p4=%h, want 1 0 %h %h %h",
                     InstrValid, ImemReq, InstrD, PCD, PCPlus4D, ins, addr, addr + 32'd4);
         else n_pass++;
         if (i < stall) begin
            ImemAck = 1'($urandom); ImemRdata = $urandom;
            step();
         end
      end
      ImemAck = 1'b0;
      PCSrc = src; PCTarget = tgt; ALUResult = alu; InstrReady = 1'b1;
      step();
      InstrReady = 1'b0; PCSrc = 2'($urandom); PCTarget = $urandom; ALUResult = $urandom;
      nxt = model_next(src, addr, tgt, alu);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_total++;
      if ({ImemReq, ImemAddr, InstrValid, InstrD, PCD, PCPlus4D} !==
          {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4})
         $display("FAIL reset_vals: req=%0b addr=%h v=%0b instr=%h pcd=%h p4=%h, want 0 0 0 %h 0 4",
                  ImemReq, ImemAddr, InstrValid, InstrD, PCD, PCPlus4D, NOP);
      else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
      n_total++;
      if (FetchFault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", FetchFault);
      else n_pass++;
`endif
      rst = 1'b0;
      step();
      n_total++;
      if ({ImemReq, ImemAddr} !== {1'b1, 32'h0})
         $display("FAIL boot_req: req=%0b addr=%h, want 1 0", ImemReq, ImemAddr);
      else n_pass++;
      cur_addr = 32'h0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++)
         do_fetch(cur_addr, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
   endtask

   task automatic test_stall();
      do_fetch(cur_addr, 0, 5, 2'b11, $urandom, $urandom, cur_addr);
   endtask

   task automatic test_branch();
      apply_reset();
      do_fetch(cur_addr, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
      do_fetch(cur_addr, 1, 0, 2'b00, 32'h0, 32'h0, cur_addr);
      do_fetch(cur_addr, 0, 0, 2'b01, 32'h0000_0040, 32'h0, cur_addr);
      do_fetch(cur_addr, 0, 0, 2'b10, 32'h0, 32'h0000_0085, cur_addr);
      do_fetch(cur_addr, 2, 1, 2'b00, 32'h0, 32'h0, cur_addr);
      n_total++;
      if (cur_addr !== 32'h0000_0088) $display("FAIL branch_seq: at %h want 88", cur_addr);
      else n_pass++;
   endtask

   task automatic test_wrap();
      do_fetch(cur_addr, 0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0, cur_addr);
      do_fetch(cur_addr, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
      do_fetch(cur_addr, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
   endtask

   task automatic test_random();
      logic [1:0]  src;
      logic [31:0] tgt, alu;
      for (int i = 0; i < 24; i++) begin
         src = 2'($urandom_range(0, 3));
         tgt = $urandom; alu = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = tgt & 32'hFFFF_FFFC;
         alu = alu & 32'hFFFF_FFFD;
`endif
         do_fetch(cur_addr, $urandom_range(0, 3), $urandom_range(0, 3), src, tgt, alu, cur_addr);
      end
   endtask

   task automatic test_reset_mid();
      ImemAck = 1'b0;
      step(); step();
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({ImemReq, ImemAddr, InstrValid, InstrD} !== {1'b0, 32'h0, 1'b0, NOP})
         $display("FAIL reset_async: req=%0b addr=%h v=%0b instr=%h, want 0 0 0 %h",
                  ImemReq, ImemAddr, InstrValid, InstrD, NOP);
      else n_pass++;
      ImemAck = 1'b1; ImemRdata = $urandom;
      step(); step();
      n_total++;
      if ({ImemReq, InstrValid, PCD} !== {1'b0, 1'b0, 32'h0})
         $display("FAIL reset_hold: req=%0b v=%0b pcd=%h, want 0 0 0", ImemReq, InstrValid, PCD);
      else n_pass++;
      rst = 1'b0;
      step();
      ImemAck = 1'b0;
      n_total++;
      if ({ImemReq, ImemAddr, InstrValid} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL late_ack: req=%0b addr=%h v=%0b, want 1 0 0", ImemReq, ImemAddr, InstrValid);
      else n_pass++;
      cur_addr = 32'h0;
      do_fetch(cur_addr, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
   endtask

   task automatic test_misalign();
      logic [31:0] nxt;
      do_fetch(cur_addr, 0, 0, 2'b01, 32'h0000_0042, 32'h0, nxt);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if ({FetchFault, ImemReq, InstrValid, InstrD} !== {1'b1, 1'b0, 1'b0, NOP})
            $display("FAIL fault_state: ff=%0b req=%0b v=%0b instr=%h, want 1 0 0 %h",
                     FetchFault, ImemReq, InstrValid, InstrD, NOP);
         else n_pass++;
         ImemAck = 1'b1; InstrReady = 1'b1;
         step();
      end
      ImemAck = 1'b0; InstrReady = 1'b0;
      apply_reset();
      n_total++;
      if ({FetchFault, ImemReq, ImemAddr} !== {1'b0, 1'b1, 32'h0})
         $display("FAIL fault_clear: ff=%0b req=%0b addr=%h, want 0 1 0", FetchFault, ImemReq, ImemAddr);
      else n_pass++;
`else
      n_total++;
      if (nxt !== 32'h0000_0040) $display("FAIL misalign_model: got %h want 40", nxt);
      else n_pass++;
      do_fetch(nxt, 0, 0, 2'b00, 32'h0, 32'h0, cur_addr);
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_wrap();
      test_random();
      test_reset_mid();
      test_misalign();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
